// File: rtl/puf_pkg.sv
// Shared definitions for the PUF authentication verifier: FSM state encoding,
// default parameter values and a width helper.
package puf_pkg;

   localparam int DEF_CH_W      = 8;
   localparam int DEF_NUM_CH    = 16;
   localparam int DEF_SETTLE    = 4;
   localparam int DEF_HD_THRESH = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      WAIT    = 3'd2,
      SAMPLE  = 3'd3,
      COMPARE = 3'd4,
      DONE    = 3'd5
   } puf_state_e;

   // Index width for a counter that walks 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/puf_popcount.sv
// Combinational population count of a W-bit vector.
module puf_popcount
   import puf_pkg::*;
#(
   parameter int W = DEF_NUM_CH
) (
   input  logic [W-1:0]             vec,
   output logic [$clog2(W+1)-1:0]   count
);

   localparam int CW = $clog2(W + 1);

   // Ripple sum of all set bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/puf_auth_verifier.sv
// Drives a challenge sequence into an arbiter PUF, collects the responses into a
// signature and grades it against an enrolled reference by Hamming distance.
module puf_auth_verifier
   import puf_pkg::*;
#(
   parameter int CH_W      = DEF_CH_W,
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int SETTLE    = DEF_SETTLE,
   parameter int HD_THRESH = DEF_HD_THRESH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [CH_W-1:0]               ch_seed,
   input  logic [NUM_CH-1:0]             expected,
   input  logic                          RESP,
   output logic [CH_W-1:0]               CH,
   output logic                          ch_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic                          fail,
   output logic [$clog2(NUM_CH+1)-1:0]   hd,
   output logic [NUM_CH-1:0]             signature,
   output logic                          LED1,
   output logic                          LED2
);

   localparam int HD_W   = $clog2(NUM_CH + 1);
   localparam int IDX_W  = idx_width(NUM_CH);
   localparam int WAIT_W = idx_width(SETTLE);

   localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_CH - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(SETTLE - 1);
   localparam logic [HD_W-1:0]   HD_THRESH_C = HD_W'(HD_THRESH);

   puf_state_e          state_r;
   logic [CH_W-1:0]     seed_r;
   logic [NUM_CH-1:0]   exp_r;
   logic [IDX_W-1:0]    idx_r;
   logic [IDX_W-1:0]    idx_inc_s;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic                resp_meta_r;
   logic                resp_sync_r;
   logic [CH_W-1:0]     ch_r;
   logic                ch_valid_r;
   logic                busy_r;
   logic                done_r;
   logic                pass_r;
   logic                fail_r;
   logic [HD_W-1:0]     hd_r;
   logic [NUM_CH-1:0]   sig_r;
   logic [NUM_CH-1:0]   diff_s;
   logic [HD_W-1:0]     pop_s;

   assign idx_inc_s = idx_r + IDX_W'(1);
   assign diff_s    = sig_r ^ exp_r;

   puf_popcount #(
      .W (NUM_CH)
   ) u_popcount (
      .vec   (diff_s),
      .count (pop_s)
   );

   // RESP comes from the arbiter with no timing relation to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_meta_r <= 1'b0;
         resp_sync_r <= 1'b0;
      end else begin
         resp_meta_r <= RESP;
         resp_sync_r <= resp_meta_r;
      end
   end

   // Authentication sequencer; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         seed_r     <= '0;
         exp_r      <= '0;
         idx_r      <= '0;
         wait_cnt_r <= '0;
         ch_r       <= '0;
         ch_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         fail_r     <= 1'b0;
         hd_r       <= '0;
         sig_r      <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r     <= 1'b0;
               busy_r     <= 1'b0;
               ch_valid_r <= 1'b0;
               if (start) begin
                  seed_r     <= ch_seed;
                  exp_r      <= expected;
                  sig_r      <= '0;
                  idx_r      <= '0;
                  pass_r     <= 1'b0;
                  fail_r     <= 1'b0;
                  ch_r       <= ch_seed;
                  ch_valid_r <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= DRIVE;
               end else begin
                  state_r    <= IDLE;
               end
            end
            DRIVE: begin
               wait_cnt_r <= '0;
               state_r    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_r == WAIT_LAST) begin
                  state_r    <= SAMPLE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
               end
            end
            SAMPLE: begin
               sig_r[idx_r] <= resp_sync_r;
               // CH for the next challenge is loaded here so it is already valid in DRIVE.
               if (idx_r < IDX_LAST) begin
                  idx_r   <= idx_inc_s;
                  ch_r    <= seed_r + CH_W'(idx_inc_s);
                  state_r <= DRIVE;
               end else begin
                  ch_valid_r <= 1'b0;
                  state_r    <= COMPARE;
               end
            end
            COMPARE: begin
               // Verdict is registered with hd so both are visible alongside done.
               hd_r    <= pop_s;
               pass_r  <= (pop_s <= HD_THRESH_C);
               fail_r  <= !(pop_s <= HD_THRESH_C);
               done_r  <= 1'b1;
               state_r <= DONE;
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r     <= 1'b0;
               busy_r     <= 1'b0;
               ch_valid_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign CH        = ch_r;
   assign ch_valid  = ch_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign hd        = hd_r;
   assign signature = sig_r;
   assign LED1      = pass_r;
   assign LED2      = fail_r;

endmodule

// File: doc/puf_auth_verifier.md
PUF_AUTH_VERIFIER -- requirements
Module: puf_auth_verifier

Interface
REQ-001 SHALL have parameter CH_W, default 8, meaning challenge width in bits.
REQ-002 SHALL have parameter NUM_CH, default 16, meaning challenges per authentication, which is also the signature width.
REQ-003 SHALL have parameter SETTLE, default 4, meaning wait cycles between challenge drive and response sample; minimum 2.
REQ-004 SHALL have parameter HD_THRESH, default 2, meaning maximum Hamming distance accepted as pass.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin an authentication.
REQ-008 SHALL have port ch_seed, input, CH_W bits: first challenge of the sequence.
REQ-009 SHALL have port expected, input, NUM_CH bits: enrolled reference signature.
REQ-010 SHALL have port RESP, input, 1 bit: arbiter response, asynchronous to clk.
REQ-011 SHALL have port CH, output, CH_W bits: challenge driven to the arbiter.
REQ-012 SHALL have port ch_valid, output, 1 bit: CH is being driven for the current challenge.
REQ-013 SHALL have port busy, output, 1 bit: high while an authentication is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have ports pass and fail, outputs, 1 bit each: verdict, held until the next start or reset.
REQ-016 SHALL have port hd, output, clog2(NUM_CH+1) bits: measured Hamming distance.
REQ-017 SHALL have port signature, output, NUM_CH bits: collected responses.
REQ-018 SHALL have ports LED1 and LED2, outputs, 1 bit each: LED1 equals pass and LED2 equals fail.

Function
REQ-019 SHALL pass RESP through a 2-flop synchronizer before use.
REQ-020 SHALL implement FSM states IDLE, DRIVE, WAIT, SAMPLE, COMPARE and DONE.
REQ-021 SHALL, in IDLE with start=1, latch ch_seed and expected, clear signature, idx, pass and fail, and go to DRIVE.
REQ-022 SHALL, in DRIVE, set CH = ch_seed + idx modulo 2^CH_W (wrapping, e.g. 0xFF+1=0x00) and ch_valid=1, then go to WAIT.
REQ-023 SHALL hold CH stable and ch_valid=1 from DRIVE through SAMPLE.
REQ-024 SHALL remain in WAIT for exactly SETTLE cycles.
REQ-025 SHALL, in SAMPLE, write the synchronized response into signature[idx] (LSB first).
REQ-026 SHALL, from SAMPLE, increment idx and go to DRIVE if idx < NUM_CH-1, otherwise go to COMPARE.
REQ-027 SHALL, in COMPARE, register hd = popcount(signature XOR latched expected).
REQ-028 SHALL, in DONE, pulse done=1, set pass=(hd <= HD_THRESH) and fail=!pass, and return to IDLE.
REQ-029 SHALL make hd == HD_THRESH a pass and hd == HD_THRESH+1 a fail.
REQ-030 SHALL assert done exactly NUM_CH*(SETTLE+2)+2 cycles after the cycle in which start is sampled.
REQ-031 SHALL hold busy=1 in every state except IDLE.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL ignore changes to ch_seed and expected after they are latched.
REQ-034 SHALL hold ch_valid=0 in IDLE, COMPARE and DONE.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE and clear CH, ch_valid, busy, done, pass, fail, hd, signature, idx, the synchronizer flops, LED1 and LED2.
REQ-036 SHALL, on rst mid-authentication, abort without asserting done, and SHALL give rst priority over start in the same cycle.

Structure
REQ-037 SHALL take the FSM state enum and default parameter constants from the shared package puf_pkg.
REQ-038 SHALL implement the Hamming-distance count as sub-module puf_popcount (combinational, NUM_CH-bit input).

Verification
REQ-039 SHALL verify: RESP tied 1, expected=0xFFFF, start -> done at cycle 98, hd=0, pass=1, LED1=1.
REQ-040 SHALL verify: RESP tied 1, expected=0x0000 -> hd=16, fail=1, LED2=1.
REQ-041 SHALL verify: RESP = parity(CH) model with expected differing in 2 bits -> pass; then expected differing in 3 bits -> fail.
REQ-042 SHALL verify: ch_seed=0xF8 -> CH sequence F8..FF, 00..07.
REQ-043 SHALL verify: rst at cycle 30 -> IDLE, all outputs 0, no done pulse; a following start completes normally.
REQ-044 SHALL verify: start re-pulsed while busy -> ignored, with a single done at cycle 98.
